render_lane_scheduler: RTL and testbench

- Parametrised dispatch/collect fabric for NUM_LANES parallel render lanes.
- Buffers incoming particle coordinates in an internal FIFO and hands each particle to exactly one enabled lane, round-robin.
- Gathers per-lane pixel outputs through one-entry holding registers.
- Merges those pixels round-robin onto a single backpressured pixel stream for the framebuffer writer.
- Sits between the particle buffer and the frame-buffer write port. Lanes are instantiated outside the block.

---
 rtl/render_lane_scheduler_pkg.sv | 23 ++
 rtl/render_lane_scheduler_rr_select.sv | 32 +++
 rtl/render_lane_scheduler.sv | 172 +++++++++++++++++
 tb/tb_render_lane_scheduler.sv | 379 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/render_lane_scheduler_pkg.sv
// Shared types, default widths and pointer-width helper for the render lane scheduler.
package render_pkg;

  localparam int DEF_COORD_W = 16;
  localparam int DEF_COLOR_W = 16;
  localparam int DEF_ADDR_W  = 16;

  typedef struct packed {
    logic [DEF_COORD_W-1:0] z;
    logic [DEF_COORD_W-1:0] y;
    logic [DEF_COORD_W-1:0] x;
  } coord_t;

  typedef struct packed {
    logic [DEF_COLOR_W-1:0] color;
    logic [DEF_ADDR_W-1:0]  addr;
  } pixel_t;

  function automatic int ptr_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/render_lane_scheduler_rr_select.sv
// Combinational round-robin picker: first request at or after start, wrapping.
module rr_select
  import render_pkg::*;
#(
  parameter int N  = 4,
  parameter int PW = ptr_w(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [PW-1:0] start_i,
  output logic [N-1:0]  grant_o,
  output logic [PW-1:0] idx_o,
  output logic          any_o
);

  int unsigned pos;

  always_comb begin
    grant_o = '0;
    idx_o   = '0;
    any_o   = 1'b0;
    pos     = 0;
    for (int i = 0; i < N; i++) begin
      pos = (32'(start_i) + 32'(i)) % N;
      if (!any_o && req_i[pos]) begin
        any_o        = 1'b1;
        grant_o[pos] = 1'b1;
        idx_o        = PW'(pos);
      end
    end
  end

endmodule

// File: rtl/render_lane_scheduler.sv
// Particle FIFO with round-robin lane dispatch, and per-lane pixel holds merged round-robin onto one stream.
module render_lane_scheduler
  import render_pkg::*;
#(
  parameter int NUM_LANES  = 4,
  parameter int COORD_W    = 16,
  parameter int COLOR_W    = 16,
  parameter int ADDR_W     = 16,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                           clk_in,
  input  logic                           rst_in,
  input  logic [NUM_LANES-1:0]           lane_enable_in,
  input  logic                           in_valid_in,
  output logic                           in_ready_out,
  input  logic [COORD_W-1:0]             in_x_in,
  input  logic [COORD_W-1:0]             in_y_in,
  input  logic [COORD_W-1:0]             in_z_in,
  output logic [NUM_LANES-1:0]           lane_valid_out,
  output logic [NUM_LANES*3*COORD_W-1:0] lane_coords_out,
  input  logic [NUM_LANES-1:0]           lane_ready_in,
  input  logic [NUM_LANES-1:0]           lane_pix_valid_in,
  input  logic [NUM_LANES*COLOR_W-1:0]   lane_color_in,
  input  logic [NUM_LANES*ADDR_W-1:0]    lane_addr_in,
  output logic [NUM_LANES-1:0]           lane_pix_ready_out,
  output logic                           pix_valid_out,
  input  logic                           pix_ready_in,
  output logic [COLOR_W-1:0]             pix_color_out,
  output logic [ADDR_W-1:0]              pix_addr_out,
  output logic [ptr_w(NUM_LANES)-1:0]    pix_lane_out,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_count_out,
  output logic                           idle_out
);

  localparam int PW    = ptr_w(NUM_LANES);
  localparam int CW    = $clog2(FIFO_DEPTH + 1);
  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int CRD_W = 3 * COORD_W;

  // ---------------- input FIFO ----------------
  logic [CRD_W-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic             push, pop;

  assign in_ready_out   = (count_q != CW'(FIFO_DEPTH));
  assign push           = in_valid_in & in_ready_out;
  assign fifo_count_out = count_q;

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      unique case ({push, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk_in) begin
    if (push) mem_q[wr_ptr_q] <= {in_z_in, in_y_in, in_x_in};
  end

  // ---------------- dispatch ----------------
  logic [NUM_LANES-1:0] lane_valid_q, eligible, disp_grant;
  logic [CRD_W-1:0]     offer_q [NUM_LANES];
  logic [PW-1:0]        disp_ptr_q, disp_idx;
  logic                 disp_any;

  assign eligible = lane_enable_in & (~lane_valid_q | lane_ready_in);
  assign pop      = (count_q != '0) & disp_any;

  rr_select #(.N(NUM_LANES), .PW(PW)) u_disp_rr (
    .req_i   (eligible),
    .start_i (disp_ptr_q),
    .grant_o (disp_grant),
    .idx_o   (disp_idx),
    .any_o   (disp_any)
  );

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      lane_valid_q <= '0;
      disp_ptr_q   <= '0;
      for (int k = 0; k < NUM_LANES; k++) offer_q[k] <= '0;
    end else begin
      for (int k = 0; k < NUM_LANES; k++) begin
        if (pop && disp_grant[k]) begin
          lane_valid_q[k] <= 1'b1;
          offer_q[k]      <= mem_q[rd_ptr_q];
        end else if (lane_ready_in[k]) begin
          lane_valid_q[k] <= 1'b0;
        end
      end
      if (pop) disp_ptr_q <= (disp_idx == PW'(NUM_LANES - 1)) ? '0 : disp_idx + PW'(1);
    end
  end

  assign lane_valid_out = lane_valid_q;
  for (genvar g = 0; g < NUM_LANES; g++) begin : g_coords
    assign lane_coords_out[g*CRD_W +: CRD_W] = offer_q[g];
  end

  // ---------------- collection ----------------
  logic [NUM_LANES-1:0] hold_valid_q, capture, coll_grant;
  logic [COLOR_W-1:0]   hold_color_q [NUM_LANES];
  logic [ADDR_W-1:0]    hold_addr_q  [NUM_LANES];
  logic [PW-1:0]        coll_ptr_q, coll_idx, pix_lane_q;
  logic [COLOR_W-1:0]   pix_color_q;
  logic [ADDR_W-1:0]    pix_addr_q;
  logic                 pix_valid_q, coll_any, load_en, take;

  // Ready comes from registered hold state, so a freed hold refills one cycle later.
  assign lane_pix_ready_out = ~hold_valid_q;
  assign capture            = lane_pix_valid_in & ~hold_valid_q;
  assign load_en            = ~pix_valid_q | pix_ready_in;
  assign take               = load_en & coll_any;

  rr_select #(.N(NUM_LANES), .PW(PW)) u_coll_rr (
    .req_i   (hold_valid_q),
    .start_i (coll_ptr_q),
    .grant_o (coll_grant),
    .idx_o   (coll_idx),
    .any_o   (coll_any)
  );

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      hold_valid_q <= '0;
      coll_ptr_q   <= '0;
      pix_valid_q  <= 1'b0;
      pix_color_q  <= '0;
      pix_addr_q   <= '0;
      pix_lane_q   <= '0;
      for (int k = 0; k < NUM_LANES; k++) begin
        hold_color_q[k] <= '0;
        hold_addr_q[k]  <= '0;
      end
    end else begin
      for (int k = 0; k < NUM_LANES; k++) begin
        if (capture[k]) begin
          hold_valid_q[k] <= 1'b1;
          hold_color_q[k] <= lane_color_in[k*COLOR_W +: COLOR_W];
          hold_addr_q[k]  <= lane_addr_in[k*ADDR_W +: ADDR_W];
        end else if (take && coll_grant[k]) begin
          hold_valid_q[k] <= 1'b0;
        end
      end
      if (load_en) pix_valid_q <= coll_any;
      if (take) begin
        pix_color_q <= hold_color_q[coll_idx];
        pix_addr_q  <= hold_addr_q[coll_idx];
        pix_lane_q  <= coll_idx;
        coll_ptr_q  <= (coll_idx == PW'(NUM_LANES - 1)) ? '0 : coll_idx + PW'(1);
      end
    end
  end

  assign pix_valid_out = pix_valid_q;
  assign pix_color_out = pix_color_q;
  assign pix_addr_out  = pix_addr_q;
  assign pix_lane_out  = pix_lane_q;

  assign idle_out = (count_q == '0) & ~|lane_valid_q & ~|hold_valid_q & ~pix_valid_q;

endmodule

// File: tb/tb_render_lane_scheduler.sv
// Randomized + directed bench for render_lane_scheduler with a queue-based scoreboard.
module tb_render_lane_scheduler;

  localparam int NL = 4;
  localparam int CRD = 48;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [NL-1:0] lane_enable;
  logic          in_valid;
  logic          in_ready;
  logic [15:0]   in_x, in_y, in_z;
  logic [NL-1:0] lane_valid;
  logic [NL*CRD-1:0] lane_coords;
  logic [NL-1:0] lane_ready;
  logic [NL-1:0] lane_pix_valid;
  logic [NL*16-1:0] lane_color;
  logic [NL*16-1:0] lane_addr;
  logic [NL-1:0] lane_pix_ready;
  logic          pix_valid, pix_ready;
  logic [15:0]   pix_color, pix_addr;
  logic [1:0]    pix_lane;
  logic [3:0]    fifo_count;
  logic          idle;

  render_lane_scheduler dut (
    .clk_in             (clk),
    .rst_in             (rst_n),
    .lane_enable_in     (lane_enable),
    .in_valid_in        (in_valid),
    .in_ready_out       (in_ready),
    .in_x_in            (in_x),
    .in_y_in            (in_y),
    .in_z_in            (in_z),
    .lane_valid_out     (lane_valid),
    .lane_coords_out    (lane_coords),
    .lane_ready_in      (lane_ready),
    .lane_pix_valid_in  (lane_pix_valid),
    .lane_color_in      (lane_color),
    .lane_addr_in       (lane_addr),
    .lane_pix_ready_out (lane_pix_ready),
    .pix_valid_out      (pix_valid),
    .pix_ready_in       (pix_ready),
    .pix_color_out      (pix_color),
    .pix_addr_out       (pix_addr),
    .pix_lane_out       (pix_lane),
    .fifo_count_out     (fifo_count),
    .idle_out           (idle)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          lane;
    logic [15:0] color;
    logic [15:0] addr;
  } pexp_t;

  logic [CRD-1:0] exp_part_q[$];
  int             exp_lane_q[$];
  pexp_t          exp_pix_q[$];
  int             exp_plane_q[$];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- monitor / scoreboard ----------------
  logic [NL-1:0]  prev_v, prev_acc, prev_en;
  logic [CRD-1:0] prev_c [NL];
  logic           prev_pv, prev_pacc;
  logic [15:0]    prev_pcol, prev_padr;
  logic [1:0]     prev_plane;
  int             nnew, pidx;
  pexp_t          rec;

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_v    = '0;
      prev_acc  = '0;
      prev_en   = '0;
      prev_pv   = 1'b0;
      prev_pacc = 1'b0;
    end else begin
      nnew = 0;
      for (int k = 0; k < NL; k++) begin
        if (prev_v[k] && !prev_acc[k]) begin
          chk("offer_hold_valid", lane_valid[k], 1'b1);
          chk("offer_hold_data", lane_coords[k*CRD +: CRD], prev_c[k]);
        end else if (lane_valid[k]) begin
          nnew++;
          chk("offer_enabled", prev_en[k], 1'b1);
          if (exp_part_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL offer_unexpected: lane %0d got %0h expected no offer", k, lane_coords[k*CRD +: CRD]);
          end else begin
            chk("offer_data", lane_coords[k*CRD +: CRD], exp_part_q.pop_front());
          end
          if (exp_lane_q.size() > 0) chk("offer_lane", k, exp_lane_q.pop_front());
        end
      end
      if (nnew > 1) begin
        checks++;
        errors++;
        $display("FAIL one_dispatch: got %0d new offers expected at most 1", nnew);
      end
      prev_en  = lane_enable;
      prev_v   = lane_valid;
      prev_acc = lane_valid & lane_ready;
      for (int k = 0; k < NL; k++) prev_c[k] = lane_coords[k*CRD +: CRD];

      if (prev_pv && !prev_pacc) begin
        chk("pix_hold_valid", pix_valid, 1'b1);
        chk("pix_hold_data", {pix_lane, pix_color, pix_addr}, {prev_plane, prev_pcol, prev_padr});
      end
      if (pix_valid && pix_ready) begin
        pidx = -1;
        for (int i = 0; i < exp_pix_q.size(); i++)
          if (pidx < 0 && exp_pix_q[i].lane == int'(pix_lane)) pidx = i;
        if (pidx < 0) begin
          checks++;
          errors++;
          $display("FAIL pix_unexpected: lane %0d color %0h addr %0h expected none", pix_lane, pix_color, pix_addr);
        end else begin
          chk("pix_data", {pix_color, pix_addr}, {exp_pix_q[pidx].color, exp_pix_q[pidx].addr});
          exp_pix_q.delete(pidx);
        end
        if (exp_plane_q.size() > 0) chk("pix_lane_order", pix_lane, exp_plane_q.pop_front());
      end
      prev_pv    = pix_valid;
      prev_pacc  = pix_valid & pix_ready;
      prev_pcol  = pix_color;
      prev_padr  = pix_addr;
      prev_plane = pix_lane;

      // record handshakes that will complete on the coming edge
      if (in_valid && in_ready) exp_part_q.push_back({in_z, in_y, in_x});
      for (int k = 0; k < NL; k++) begin
        if (lane_pix_valid[k] && lane_pix_ready[k]) begin
          rec.lane  = k;
          rec.color = lane_color[k*16 +: 16];
          rec.addr  = lane_addr[k*16 +: 16];
          exp_pix_q.push_back(rec);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic quiet();
    in_valid       = 1'b0;
    lane_pix_valid = '0;
  endtask

  task automatic rand_part();
    in_x = 16'($urandom);
    in_y = 16'($urandom);
    in_z = 16'($urandom);
  endtask

  task automatic flush_q();
    exp_part_q.delete();
    exp_lane_q.delete();
    exp_pix_q.delete();
    exp_plane_q.delete();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    quiet();
    #1;
    flush_q();
    @(negedge clk);
    #2;
    rst_n = 1'b1;
    tick();
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while (!idle && n < budget) begin
      tick();
      n++;
    end
    chk("drain_idle", idle, 1'b1);
  endtask

  task automatic rand_cycle();
    in_valid       = ($urandom_range(0, 1) == 1);
    rand_part();
    lane_enable    = NL'($urandom);
    lane_ready     = NL'($urandom);
    lane_pix_valid = NL'($urandom);
    lane_color     = {$urandom, $urandom};
    lane_addr      = {$urandom, $urandom};
    pix_ready      = ($urandom_range(0, 3) != 0);
  endtask

  int acc;
  int n;

  initial begin
    rst_n = 1'b0;
    lane_enable = '1;
    lane_ready = '1;
    pix_ready = 1'b1;
    lane_color = '0;
    lane_addr = '0;
    in_x = '0; in_y = '0; in_z = '0;
    quiet();
    repeat (2) @(negedge clk);
    chk("rst_lane_valid", lane_valid, 0);
    chk("rst_pix_valid", pix_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_idle", idle, 1);
    chk("rst_fifo_count", fifo_count, 0);
    chk("rst_pix_ready", lane_pix_ready, 4'hf);
    chk("rst_pix_data", {pix_color, pix_addr, pix_lane}, 0);
    chk("rst_coords", lane_coords, 0);
    #2;
    rst_n = 1'b1;
    tick();

    // all lanes enabled and ready: strict 0,1,2,3 rotation, 2-cycle latency
    for (int i = 0; i < 8; i++) exp_lane_q.push_back(i % 4);
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1;
      rand_part();
      tick();
      if (i == 0) begin
        chk("latency_early", lane_valid, 0);
        chk("fifo_count_one", fifo_count, 1);
      end
      if (i == 1) chk("latency_t2", lane_valid[0], 1'b1);
    end
    quiet();
    repeat (6) tick();
    chk("t1_lanes_done", exp_lane_q.size(), 0);

    // only lanes 1 and 3 enabled
    lane_enable = 4'b1010;
    exp_lane_q.push_back(1); exp_lane_q.push_back(3);
    exp_lane_q.push_back(1); exp_lane_q.push_back(3);
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      rand_part();
      tick();
    end
    quiet();
    repeat (6) tick();
    chk("t2_lanes_done", exp_lane_q.size(), 0);

    // pending offer survives enable drop
    lane_ready = 4'b1101;
    exp_lane_q.push_back(1);
    in_valid = 1'b1;
    rand_part();
    tick();
    quiet();
    n = 0;
    while (!lane_valid[1] && n < 10) begin
      tick();
      n++;
    end
    chk("offer_seen", lane_valid[1], 1'b1);
    lane_enable = 4'b1000;
    repeat (5) tick();
    chk("offer_kept", lane_valid[1], 1'b1);
    lane_ready = 4'b1111;
    tick();
    chk("offer_released", lane_valid[1], 1'b0);

    // no lane ready: 4 offers held, FIFO fills, extra pushes refused
    lane_enable = 4'b1111;
    lane_ready  = 4'b0000;
    for (int i = 0; i < 12; i++) exp_lane_q.push_back((i + 2) % 4);
    acc = 0;
    for (int i = 0; i < 20; i++) begin
      in_valid = 1'b1;
      rand_part();
      if (in_ready) acc++;
      tick();
    end
    quiet();
    chk("full_count", fifo_count, 8);
    chk("full_in_ready", in_ready, 0);
    chk("full_offers", lane_valid, 4'hf);
    chk("full_accepted", acc, 12);
    lane_ready = 4'b1111;
    repeat (20) tick();
    chk("full_drained", exp_part_q.size(), 0);
    chk("full_lanes_done", exp_lane_q.size(), 0);
    chk("full_idle", idle, 1'b1);

    // four simultaneous pixels drain 0,1,2,3 on consecutive cycles
    do_reset();
    pix_ready = 1'b1;
    for (int i = 0; i < 4; i++) exp_plane_q.push_back(i);
    lane_pix_valid = 4'b1111;
    lane_color = {$urandom, $urandom};
    lane_addr  = {$urandom, $urandom};
    tick();
    quiet();
    chk("holds_full", lane_pix_ready, 0);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("pix_back_to_back", pix_valid, 1'b1);
    end
    tick();
    chk("pix_order_done", exp_plane_q.size(), 0);
    chk("pix_idle", idle, 1'b1);

    // stalled output while lanes keep streaming
    pix_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      lane_pix_valid = 4'b1111;
      lane_color = {$urandom, $urandom};
      lane_addr  = {$urandom, $urandom};
      tick();
    end
    quiet();
    chk("stall_holds_full", lane_pix_ready, 0);
    chk("stall_pix_valid", pix_valid, 1'b1);
    pix_ready = 1'b1;
    repeat (10) tick();
    chk("stall_drained", exp_pix_q.size(), 0);

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      rand_cycle();
      tick();
    end
    quiet();
    lane_enable = 4'b1111;
    lane_ready  = 4'b1111;
    pix_ready   = 1'b1;
    wait_idle(200);
    chk("rand_parts_done", exp_part_q.size(), 0);
    chk("rand_pix_done", exp_pix_q.size(), 0);

    // asynchronous reset in the middle of traffic
    for (int i = 0; i < 25; i++) begin
      rand_cycle();
      tick();
    end
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_lane_valid", lane_valid, 0);
    chk("arst_pix_valid", pix_valid, 1'b0);
    chk("arst_in_ready", in_ready, 1'b1);
    chk("arst_idle", idle, 1'b1);
    chk("arst_count", fifo_count, 0);
    quiet();
    flush_q();
    @(negedge clk);
    #2;
    rst_n = 1'b1;
    repeat (4) tick();
    chk("post_rst_idle", idle, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
